pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage in-order pipeline (fetch, decode, execute, memory, writeback).
- Detects load-use hazards at decode.
- Squashes younger instructions on execute-stage branch mispredict.
- Freezes the front of the pipeline for fixed-latency multi-cycle execute ops (mul/div).
- Freezes the whole pipeline while data memory is not ready.
Drives per-stage stall (hold pipe register) and flush (stage emits an all-zero bubble to the next stage) signals.

Parameters:
MC_LATENCY, 4, total stall cycles for a multi-cycle execute op; legal range 1..16.
CNT_W, 4, width of the multi-cycle down-counter; must satisfy 2^CNT_W > MC_LATENCY-1.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-low
dec_valid  in  1  decode holds a real instruction
dec_rs1_addr  in  5  decode rs1 address
dec_rs2_addr  in  5  decode rs2 address
dec_use_rs1  in  1  decode instruction reads rs1
dec_use_rs2  in  1  decode instruction reads rs2
ex_valid  in  1  execute holds a real instruction
ex_rd_addr  in  5  execute destination register
ex_is_load  in  1  execute instruction is a load
ex_multi_start  in  1  execute instruction is multi-cycle; held while it sits in execute
ex_mispredict  in  1  branch in execute resolved opposite to prediction
mem_req  in  1  memory stage has an outstanding data access
mem_ready  in  1  data memory completes the access this cycle
fetch_stall, fetch_flush  out  1 each  fetch stage controls
dec_stall, dec_flush  out  1 each  decode stage controls
ex_stall, ex_flush  out  1 each  execute stage controls
mem_stall, mem_flush  out  1 each  memory stage controls
multi_busy  out  1  state is MULTI
multi_done  out  1  state is MDONE; multi-cycle result valid this cycle

Behaviour:
- While rst==0, every output is 0. Next state is RUN and the counter is 0, regardless of other inputs. Reset asserted mid-MULTI abandons the op.
- States: RUN, MULTI, MDONE.
- Internal signal memwait = mem_req & ~mem_ready.
- Hazard conditions are evaluated combinationally in priority order. The first match below drives the outputs; all outputs not listed are 0.
- P1, memwait: all four stalls = 1, mem_flush = 1. ex_mispredict and ex_multi_start are ignored this cycle; both are re-presented by the held execute instruction.
- P2, start or continue a multi-cycle op: (state==RUN & ex_valid & ex_multi_start) or state==MULTI. Drive fetch_stall = dec_stall = ex_stall = 1 and ex_flush = 1.
- P3, mispredict: ex_valid & ex_mispredict. Drive fetch_flush = dec_flush = 1; the two younger instructions are squashed. A simultaneous load-use condition is discarded.
- P4, load-use: dec_valid & ex_valid & ex_is_load & ex_rd_addr != 0, and (dec_use_rs1 & rs1 == rd) or (dec_use_rs2 & rs2 == rd). Drive fetch_stall = dec_stall = 1 and dec_flush = 1 for exactly one cycle.
- FSM transitions:
  - RUN: on P2 start with no memwait, load cnt <= MC_LATENCY-1. Next state is MDONE if MC_LATENCY==1, else MULTI.
  - MULTI: cnt <= cnt-1 each cycle, including memwait cycles (the unit runs freely). When cnt==1, next state is MDONE.
  - MDONE: ex_multi_start is ignored, no P2 stall. Hold in MDONE while memwait; otherwise go to RUN.
- Stall count: a multi-cycle op with no memwait stalls exactly MC_LATENCY cycles (start cycle plus MC_LATENCY-1 MULTI cycles), then spends one MDONE cycle in which it advances.
- ex_multi_start & ex_mispredict are never both set; the decoder guarantees this. The bench must not drive both.
- Register x0 never causes a hazard.

Optional Feature:
PIPELINE_PERF_COUNTER_EN
- With the macro: extra outputs perf_stall_cycles[31:0] and perf_flush_events[31:0], reset to 0.
  - perf_stall_cycles increments on every cycle with fetch_stall==1.
  - perf_flush_events increments on every cycle where P3 wins.
  - Both wrap modulo 2^32.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- PipelineTypes package:
  - HazardCtrlState enum {RUN, MULTI, MDONE}.
  - StageCtrl struct {stall, flush}.
  - ZERO_REG constant.
- Register address type comes from BasicTypes.
- One natural sub-module: multicycle_sequencer (FSM plus down-counter; outputs busy/done/stall request). The priority mux stays in the top module.

Test Plan:
- Load x5 in execute, decode add reads rs2=x5 with dec_use_rs2=1 -> 1 cycle of fetch_stall=dec_stall=dec_flush=1, then all 0. Same case with rd=x0 -> no stall.
- ex_multi_start=1 held, MC_LATENCY=4 -> fetch/dec/ex_stall and ex_flush high for 4 cycles, multi_busy high for cycles 2-4, multi_done high cycle 5 with no stall, then RUN.
- ex_mispredict=1 coinciding with a load-use match -> fetch_flush=dec_flush=1, dec_stall=0, one cycle.
- mem_req=1, mem_ready=0 for 3 cycles during MULTI with MC_LATENCY=4 -> all stalls and mem_flush high; counter still expires; MDONE held until mem_ready=1, then RUN next cycle.
- rst=0 for one cycle during MULTI -> all outputs 0 that cycle, state RUN afterwards, no multi_done pulse.
- With PIPELINE_PERF_COUNTER_EN: one load-use, one mispredict, one 4-cycle multi op -> perf_stall_cycles=5, perf_flush_events=1.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states,
// per-stage stall/flush pair, register address type and the x0 constant.
package pipeline_hazard_controller_pkg;

  // Architectural register address (x0..x31).
  typedef logic [4:0] reg_addr_t;

  // Register x0 is hard-wired to zero and can never create a dependency.
  localparam reg_addr_t ZERO_REG = 5'd0;

  // Multi-cycle sequencer states. RUN encodes as 0 so a cleared state bus reads RUN.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULTI = 2'd1,
    MDONE = 2'd2
  } hazard_ctrl_state_e;

  // Per-stage control: stall holds the pipe register, flush emits a bubble.
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

  // True when a decode source operand is read and names the execute destination.
  function automatic logic src_hit(input logic used, input reg_addr_t src, input reg_addr_t rd);
    return used && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of pipeline status inputs and stage control outputs between the
// datapath (master) and the hazard controller (slave). The state field is a
// debug view of the multi-cycle sequencer.
//
// Handshake: purely level-based, no valid/ready pairing. mem_req qualifies
// mem_ready; an access completes in a cycle where both are high, and while
// mem_req is high with mem_ready low the whole pipeline is frozen.
interface pipeline_hazard_controller_if;
  import pipeline_hazard_controller_pkg::*;

  logic               dec_valid;
  reg_addr_t          dec_rs1_addr;
  reg_addr_t          dec_rs2_addr;
  logic               dec_use_rs1;
  logic               dec_use_rs2;
  logic               ex_valid;
  reg_addr_t          ex_rd_addr;
  logic               ex_is_load;
  logic               ex_multi_start;
  logic               ex_mispredict;
  logic               mem_req;
  logic               mem_ready;

  logic               fetch_stall;
  logic               fetch_flush;
  logic               dec_stall;
  logic               dec_flush;
  logic               ex_stall;
  logic               ex_flush;
  logic               mem_stall;
  logic               mem_flush;
  logic               multi_busy;
  logic               multi_done;
  hazard_ctrl_state_e state;

  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_use_rs1, dec_use_rs2,
    output ex_valid, ex_rd_addr, ex_is_load, ex_multi_start, ex_mispredict,
    output mem_req, mem_ready,
    input  fetch_stall, fetch_flush, dec_stall, dec_flush,
    input  ex_stall, ex_flush, mem_stall, mem_flush,
    input  multi_busy, multi_done, state
  );

  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_use_rs1, dec_use_rs2,
    input  ex_valid, ex_rd_addr, ex_is_load, ex_multi_start, ex_mispredict,
    input  mem_req, mem_ready,
    output fetch_stall, fetch_flush, dec_stall, dec_flush,
    output ex_stall, ex_flush, mem_stall, mem_flush,
    output multi_busy, multi_done, state
  );

endinterface

// File: rtl/pipeline_hazard_controller_multicycle_sequencer.sv
// Multi-cycle execute sequencer: RUN/MULTI/MDONE FSM plus a down-counter.
// A start accepted in RUN stalls for MC_LATENCY cycles in total (start cycle
// plus MC_LATENCY-1 MULTI cycles), then spends one MDONE cycle advancing.
// The unit counts freely through memory waits; MDONE is held while memory waits.
module pipeline_hazard_controller_multicycle_sequencer
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               memwait,
  output logic               busy,
  output logic               done,
  output logic               stall_req,
  output hazard_ctrl_state_e state
);

  hazard_ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // State and counter register; active-low synchronous reset abandons any op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        // A memory wait freezes execute, so the op is not launched until it clears.
        if (start && !memwait) begin
          cnt_d   = CNT_W'(MC_LATENCY - 1);
          state_d = (MC_LATENCY == 1) ? MDONE : MULTI;
        end
      end
      MULTI: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MDONE;
      end
      MDONE: begin
        if (!memwait) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    stall_req = 1'b0;
    state     = RUN;
    if (rst) begin
      busy      = (state_q == MULTI);
      done      = (state_q == MDONE);
      stall_req = ((state_q == RUN) && start) || (state_q == MULTI);
      state     = state_q;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: priority mux producing per-stage stall/flush
// for memory waits, multi-cycle execute ops, mispredicts and load-use hazards.
// Optional build macro PIPELINE_PERF_COUNTER_EN adds stall-cycle and
// flush-event counters as extra outputs.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_hazard_controller_if.slave  hz
`ifdef PIPELINE_PERF_COUNTER_EN
  ,
  output logic [31:0]                  perf_stall_cycles,
  output logic [31:0]                  perf_flush_events
`endif
);

  logic        memwait;
  logic        multi_start;
  logic        mispredict;
  logic        load_use;
  logic        seq_stall_req;
  logic        p3_win;
  stage_ctrl_t fetch_c, dec_c, ex_c, mem_c;

  assign memwait     = hz.mem_req & ~hz.mem_ready;
  assign multi_start = hz.ex_valid & hz.ex_multi_start;
  assign mispredict  = hz.ex_valid & hz.ex_mispredict;
  assign load_use    = hz.dec_valid & hz.ex_valid & hz.ex_is_load &
                       (hz.ex_rd_addr != ZERO_REG) &
                       (src_hit(hz.dec_use_rs1, hz.dec_rs1_addr, hz.ex_rd_addr) |
                        src_hit(hz.dec_use_rs2, hz.dec_rs2_addr, hz.ex_rd_addr));

  pipeline_hazard_controller_multicycle_sequencer #(
    .MC_LATENCY (MC_LATENCY),
    .CNT_W      (CNT_W)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (multi_start),
    .memwait   (memwait),
    .busy      (hz.multi_busy),
    .done      (hz.multi_done),
    .stall_req (seq_stall_req),
    .state     (hz.state)
  );

  // Priority mux: memory wait, then multi-cycle op, then mispredict, then load-use.
  always_comb begin
    fetch_c = '0;
    dec_c   = '0;
    ex_c    = '0;
    mem_c   = '0;
    p3_win  = 1'b0;
    if (!rst) begin
      // everything held low during reset
    end else if (memwait) begin
      // Whole pipe frozen; mem emits a bubble to writeback. Execute-stage
      // requests are re-presented next cycle by the held instruction.
      fetch_c.stall = 1'b1;
      dec_c.stall   = 1'b1;
      ex_c.stall    = 1'b1;
      mem_c.stall   = 1'b1;
      mem_c.flush   = 1'b1;
    end else if (seq_stall_req) begin
      fetch_c.stall = 1'b1;
      dec_c.stall   = 1'b1;
      ex_c.stall    = 1'b1;
      ex_c.flush    = 1'b1;
    end else if (mispredict) begin
      // Squash the two younger instructions; any load-use match dies with them.
      fetch_c.flush = 1'b1;
      dec_c.flush   = 1'b1;
      p3_win        = 1'b1;
    end else if (load_use) begin
      fetch_c.stall = 1'b1;
      dec_c.stall   = 1'b1;
      dec_c.flush   = 1'b1;
    end
  end

  assign hz.fetch_stall = fetch_c.stall;
  assign hz.fetch_flush = fetch_c.flush;
  assign hz.dec_stall   = dec_c.stall;
  assign hz.dec_flush   = dec_c.flush;
  assign hz.ex_stall    = ex_c.stall;
  assign hz.ex_flush    = ex_c.flush;
  assign hz.mem_stall   = mem_c.stall;
  assign hz.mem_flush   = mem_c.flush;

`ifdef PIPELINE_PERF_COUNTER_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Free-running wrap-around counters of stalled cycles and mispredict flushes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fetch_c.stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (p3_win)        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = rst ? stall_cnt_q : 32'd0;
  assign perf_flush_events = rst ? flush_cnt_q : 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller (MC_LATENCY=4).
// Control vector bit order: {fetch_stall, fetch_flush, dec_stall, dec_flush,
// ex_stall, ex_flush, mem_stall, mem_flush, multi_busy, multi_done}.
// Define PIPELINE_PERF_COUNTER_EN to also cover the performance counters.
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  localparam logic [9:0] IDLE     = 10'b00_00_00_00_00;
  localparam logic [9:0] LOADUSE  = 10'b10_11_00_00_00;
  localparam logic [9:0] MISPRED  = 10'b01_01_00_00_00;
  localparam logic [9:0] M_START  = 10'b10_10_11_00_00;
  localparam logic [9:0] M_BUSY   = 10'b10_10_11_00_10;
  localparam logic [9:0] M_DONE   = 10'b00_00_00_00_01;
  localparam logic [9:0] MW_RUN   = 10'b10_10_10_11_00;
  localparam logic [9:0] MW_MULTI = 10'b10_10_10_11_10;
  localparam logic [9:0] MW_MDONE = 10'b10_10_10_11_01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if hz_if ();

`ifdef PIPELINE_PERF_COUNTER_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_events;
`endif

  pipeline_hazard_controller #(
    .MC_LATENCY (4),
    .CNT_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
`ifdef PIPELINE_PERF_COUNTER_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Watchdog: the bench is a fixed linear sequence, this only guards a stuck clock.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz_if.dec_valid      = 1'b0;
    hz_if.dec_rs1_addr   = '0;
    hz_if.dec_rs2_addr   = '0;
    hz_if.dec_use_rs1    = 1'b0;
    hz_if.dec_use_rs2    = 1'b0;
    hz_if.ex_valid       = 1'b0;
    hz_if.ex_rd_addr     = '0;
    hz_if.ex_is_load     = 1'b0;
    hz_if.ex_multi_start = 1'b0;
    hz_if.ex_mispredict  = 1'b0;
    hz_if.mem_req        = 1'b0;
    hz_if.mem_ready      = 1'b0;
  endtask

  task automatic drive_load_use(input reg_addr_t rd, input reg_addr_t rs1, input logic u1,
                                input reg_addr_t rs2, input logic u2);
    hz_if.ex_valid     = 1'b1;
    hz_if.ex_is_load   = 1'b1;
    hz_if.ex_rd_addr   = rd;
    hz_if.dec_valid    = 1'b1;
    hz_if.dec_rs1_addr = rs1;
    hz_if.dec_use_rs1  = u1;
    hz_if.dec_rs2_addr = rs2;
    hz_if.dec_use_rs2  = u2;
  endtask

  function automatic logic [9:0] ctl();
    return {hz_if.fetch_stall, hz_if.fetch_flush, hz_if.dec_stall, hz_if.dec_flush,
            hz_if.ex_stall, hz_if.ex_flush, hz_if.mem_stall, hz_if.mem_flush,
            hz_if.multi_busy, hz_if.multi_done};
  endfunction

  // ---------------- scoreboard checks ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [9:0] exp);
    #1;
    chk(tag, 32'(ctl()), 32'(exp));
  endtask

  task automatic chk_state(input string tag, input hazard_ctrl_state_e exp);
    chk(tag, 32'(hz_if.state), 32'(exp));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clear_inputs();
    // Reset with a multi-cycle request present: outputs must still be zero.
    rst = 1'b0;
    hz_if.ex_valid       = 1'b1;
    hz_if.ex_multi_start = 1'b1;
    #2;
    chk_ctl("reset_outputs", IDLE);
    chk_state("reset_state", RUN);
    tick();
    tick();
    clear_inputs();
    rst = 1'b1;
    chk_ctl("idle_after_reset", IDLE);
    chk_state("idle_state", RUN);

    // Load x5 in execute, decode reads rs2=x5.
    drive_load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    chk_ctl("loaduse_rs2", LOADUSE);
    tick();
    clear_inputs();  // load moved on, execute now holds the bubble
    chk_ctl("loaduse_released", IDLE);
    tick();

    // Same with x0 as destination: never a hazard.
    drive_load_use(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    chk_ctl("loaduse_x0", IDLE);
    tick();

    // rs1 match only counts when rs1 is actually read.
    drive_load_use(5'd9, 5'd9, 1'b0, 5'd3, 1'b1);
    chk_ctl("loaduse_rs1_unused", IDLE);
    hz_if.dec_use_rs1 = 1'b1;
    chk_ctl("loaduse_rs1", LOADUSE);
    hz_if.ex_is_load = 1'b0;
    chk_ctl("nonload_no_hazard", IDLE);
    tick();

    // Mispredict coinciding with a load-use match: squash wins.
    clear_inputs();
    drive_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    hz_if.ex_mispredict = 1'b1;
    chk_ctl("mispred_over_loaduse", MISPRED);
    tick();
    clear_inputs();
    chk_ctl("mispred_one_cycle", IDLE);
    tick();

    // Multi-cycle op, no memory waits: 4 stall cycles then one MDONE.
    hz_if.ex_valid       = 1'b1;
    hz_if.ex_multi_start = 1'b1;
    chk_ctl("multi_c1", M_START);
    tick();
    chk_ctl("multi_c2", M_BUSY);
    chk_state("multi_c2_state", MULTI);
    tick();
    chk_ctl("multi_c3", M_BUSY);
    tick();
    chk_ctl("multi_c4", M_BUSY);
    tick();
    chk_ctl("multi_c5_done", M_DONE);
    chk_state("multi_c5_state", MDONE);
    tick();
    clear_inputs();
    chk_ctl("multi_back_to_run", IDLE);
    chk_state("multi_run_state", RUN);
    tick();

    // Multi-cycle op with memory waits during MULTI and into MDONE.
    hz_if.ex_valid       = 1'b1;
    hz_if.ex_multi_start = 1'b1;
    chk_ctl("mw_c1", M_START);
    tick();
    hz_if.mem_req   = 1'b1;
    hz_if.mem_ready = 1'b0;
    chk_ctl("mw_c2", MW_MULTI);
    tick();
    chk_ctl("mw_c3", MW_MULTI);
    tick();
    chk_ctl("mw_c4", MW_MULTI);
    tick();
    chk_ctl("mw_c5_mdone_held", MW_MDONE);
    chk_state("mw_c5_state", MDONE);
    tick();
    hz_if.mem_ready = 1'b1;
    chk_ctl("mw_c6_done", M_DONE);
    tick();
    clear_inputs();
    chk_ctl("mw_back_to_run", IDLE);
    chk_state("mw_run_state", RUN);

    // Memory wait in RUN overrides a mispredict.
    hz_if.ex_valid      = 1'b1;
    hz_if.ex_mispredict = 1'b1;
    hz_if.mem_req       = 1'b1;
    hz_if.mem_ready     = 1'b0;
    chk_ctl("memwait_over_mispred", MW_RUN);
    hz_if.mem_ready = 1'b1;
    chk_ctl("mem_ready_completes", MISPRED);
    tick();
    clear_inputs();
    tick();

    // Reset for one cycle in the middle of a multi-cycle op.
    hz_if.ex_valid       = 1'b1;
    hz_if.ex_multi_start = 1'b1;
    chk_ctl("rstmid_c1", M_START);
    tick();
    chk_ctl("rstmid_c2", M_BUSY);
    tick();
    clear_inputs();
    rst = 1'b0;
    chk_ctl("rstmid_in_reset", IDLE);
    tick();
    rst = 1'b1;
    chk_ctl("rstmid_after", IDLE);
    chk_state("rstmid_state", RUN);
    tick();
    chk_ctl("rstmid_no_done", IDLE);

`ifdef PIPELINE_PERF_COUNTER_EN
    chk("perf_stall_after_reset", perf_stall_cycles, 32'd0);
    chk("perf_flush_after_reset", perf_flush_events, 32'd0);
    // One load-use, one mispredict, one 4-cycle multi op.
    drive_load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    clear_inputs();
    hz_if.ex_valid      = 1'b1;
    hz_if.ex_mispredict = 1'b1;
    tick();
    clear_inputs();
    hz_if.ex_valid       = 1'b1;
    hz_if.ex_multi_start = 1'b1;
    repeat (5) tick();
    clear_inputs();
    tick();
    chk("perf_stall_cycles", perf_stall_cycles, 32'd5);
    chk("perf_flush_events", perf_flush_events, 32'd1);
`endif

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
